demux_stream_router: RTL
========================

Name: demux_stream_router

Overview:
- Parametrised, registered 1-to-CHANNELS demultiplexer; successor to the combinational 1:4 demux.
- Routes a single valid/ready input stream of WIDTH-bit words to one of CHANNELS output channels.
- Each channel has a one-entry output slot with its own valid/ready handshake.
- Two routing modes: addressed (in_sel chooses the channel) and round-robin (an internal pointer chooses the channel).
- Sits between a single producer (e.g. serial receiver) and per-lane consumers.

Parameters:
- WIDTH, 8, data word width in bits.
- CHANNELS, 4, number of output channels (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= CHANNELS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  word to route.
- in_sel  input  SEL_W  target channel in addressed mode.
- rr_mode  input  1  1 = round-robin routing, 0 = addressed routing.
- out_valid  output  CHANNELS  per-channel slot full.
- out_ready  input  CHANNELS  per-channel consumer accepts.
- out_data  output  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- bad_sel  output  1  one-cycle pulse when an out-of-range select was accepted.
- rr_ptr_o  output  SEL_W  current round-robin pointer (debug/verification).

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, bad_sel=0, rr_ptr=0.
  - in_ready is combinational; with all slots empty it is 1 after reset.
- Target channel: T = rr_mode ? rr_ptr : in_sel.
- Transfer: in_valid && in_ready at edge k.
  - Slot T loads in_data; out_valid[T]=1 from cycle k+1 (latency 1).
- Slot occupancy:
  - Slot i empties on out_valid[i] && out_ready[i].
  - Simultaneous drain and load of the same slot keeps out_valid[i]=1 and loads the new data, giving full throughput of one word per cycle per channel.
- in_ready:
  - in_ready = (T >= CHANNELS) || !out_valid[T] || out_ready[T].
  - in_ready depends combinationally on out_ready and on in_sel/rr_mode; it does not depend on in_valid.
- Out-of-range select (T >= CHANNELS, addressed mode only):
  - The word is accepted and discarded.
  - No slot changes.
  - bad_sel=1 in cycle k+1 only.
- Stable output: while out_valid[i] && !out_ready[i], out_data[i] holds stable.
- Channel independence: a blocked channel stalls the input only when it is the current target; other channels keep draining independently.
- Round-robin pointer:
  - rr_ptr advances on each accepted transfer while rr_mode=1.
  - It wraps from CHANNELS-1 to 0.
  - It holds while rr_mode=0.
  - Toggling rr_mode does not reset rr_ptr.
- Round-robin blocking: if the pointed slot is full and not draining, input stalls; no skipping to a free channel.
- Reset mid-operation: all slots are cleared, any buffered data is lost, and rr_ptr returns to 0 on the same edge.
- No internal state machine beyond the per-slot full flags and rr_ptr.

Optional Feature:
- Macro: DEMUX_STREAM_CNT_EN.
- When defined:
  - Adds output port cnt_out, CHANNELS*16 bits wide.
  - Holds per-channel counters of delivered words (out_valid[i] && out_ready[i]).
  - Counters wrap 65535 to 0.
  - Counters clear on rst.
  - Counters are readable the cycle after each delivery.
- When undefined: the port and the counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/include demux_stream_pkg:
  - Default WIDTH/CHANNELS/SEL_W constants.
  - Counter width constant CNT_W=16.
  - Mode encodings RR_MODE_ADDR=0, RR_MODE_RR=1.
- One sub-module, demux_out_slot:
  - One-entry register holding data and a valid flag.
  - Inputs: load, drain, data.
  - Outputs: valid, data.
  - Optional per-slot counter under the same macro.
  - Instantiated CHANNELS times in a generate loop.
- Top level holds the target decode, in_ready mux, rr_ptr and bad_sel.

Test Plan:
- Reset/idle: rst=1 for 2 cycles with in_valid=1 → out_valid=0, rr_ptr_o=0, bad_sel=0; in_ready=1 after rst drops.
- Addressed routing: rr_mode=0, send 0xA5 with sel=2, all out_ready=1 → out_valid=4'b0100 and out_data[23:16]=0xA5 one cycle later; other channels stay 0.
- Backpressure: out_ready[1]=0, two words to sel=1 → first held stable, in_ready=0 for the second; raise out_ready[1] → second delivered the next cycle, none lost or duplicated.
- Round-robin wrap: rr_mode=1, 6 back-to-back words 0x10..0x15 with all ready → channels 0,1,2,3,0,1 in order; rr_ptr_o ends at 2.
- Out-of-range: CHANNELS=3, SEL_W=2, sel=3 word → accepted, bad_sel pulses exactly one cycle, no out_valid asserted.
- Counter (DEMUX_STREAM_CNT_EN): deliver 5 words to ch0 → cnt_out ch0=5; preload near wrap so that 65536 words give 0; rst mid-stream clears all counters and slots.

Source files
------------

// File: rtl/demux_stream_pkg.sv
// Shared constants for the demux_stream_router codebase slice.
// Optional build macro: DEMUX_STREAM_CNT_EN (per-channel delivery counters).
package demux_stream_pkg;

    // Default geometry of the router
    localparam int WIDTH_DEF    = 8;
    localparam int CHANNELS_DEF = 4;
    localparam int SEL_W_DEF    = 2;

    // Width of each per-channel delivery counter
    localparam int CNT_W = 16;

    // Routing mode encodings for rr_mode
    localparam logic RR_MODE_ADDR = 1'b0;
    localparam logic RR_MODE_RR   = 1'b1;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output slot: holds a data word and a full flag.
// A load in the same cycle as a drain keeps the slot full with the new word,
// so a channel can sustain one word per cycle.
// Optional build macro: DEMUX_STREAM_CNT_EN adds a wrapping delivery counter.
module demux_out_slot
    import demux_stream_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
`ifdef DEMUX_STREAM_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_o
`endif
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             deliver_s;

    // A delivery only happens when the slot actually holds a word
    assign deliver_s = drain_i & valid_q;

    // Next-state for the full flag and the held word
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (deliver_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slot registers with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= {WIDTH{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

`ifdef DEMUX_STREAM_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Delivered-word counter, wraps naturally at 2**CNT_W
    always_comb begin
        if (deliver_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/demux_stream_router.sv
// Registered 1-to-CHANNELS stream demultiplexer with addressed and
// round-robin routing. Each channel owns a one-entry output slot.
// An out-of-range addressed select is accepted, dropped and flagged on bad_sel.
// Optional build macro: DEMUX_STREAM_CNT_EN adds cnt_out (per-channel counters).
module demux_stream_router
    import demux_stream_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int SEL_W    = SEL_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      rr_mode,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      bad_sel,
    output logic [SEL_W-1:0]          rr_ptr_o
`ifdef DEMUX_STREAM_CNT_EN
    ,
    output logic [CHANNELS*CNT_W-1:0] cnt_out
`endif
);

    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(CHANNELS);

    logic [SEL_W-1:0]    rr_ptr_q;
    logic [SEL_W-1:0]    rr_ptr_d;
    logic                bad_sel_q;
    logic                bad_sel_d;
    logic [SEL_W-1:0]    tgt_s;
    logic                tgt_ok_s;
    logic                sel_full_s;
    logic                sel_ready_s;
    logic                accept_s;
    logic [CHANNELS-1:0] load_s;
    logic [CHANNELS-1:0] drain_s;

    assign tgt_s    = (rr_mode == RR_MODE_RR) ? rr_ptr_q : in_sel;
    assign tgt_ok_s = ({1'b0, tgt_s} < CH_LIMIT);

    // Look up full/ready of the targeted slot without indexing past CHANNELS
    always_comb begin
        sel_full_s  = 1'b0;
        sel_ready_s = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            sel_full_s  = sel_full_s  | (out_valid[i] & (tgt_s == SEL_W'(i)));
            sel_ready_s = sel_ready_s | (out_ready[i] & (tgt_s == SEL_W'(i)));
        end
    end

    // Input is stalled only by a full, non-draining target slot
    assign in_ready = ~tgt_ok_s | ~sel_full_s | sel_ready_s;
    assign accept_s = in_valid & in_ready;
    assign drain_s  = out_valid & out_ready;

    // One-hot load decode for the accepted word
    always_comb begin
        load_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            load_s[i] = accept_s & tgt_ok_s & (tgt_s == SEL_W'(i));
        end
    end

    // Round-robin pointer advance with wrap, and out-of-range flag
    always_comb begin
        if (accept_s && (rr_mode == RR_MODE_RR)) begin
            if (rr_ptr_q == PTR_LAST) begin
                rr_ptr_d = {SEL_W{1'b0}};
            end else begin
                rr_ptr_d = rr_ptr_q + SEL_W'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        bad_sel_d = accept_s & ~tgt_ok_s & (rr_mode == RR_MODE_ADDR);
    end

    // Pointer and bad_sel registers with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= {SEL_W{1'b0}};
            bad_sel_q <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            bad_sel_q <= bad_sel_d;
        end
    end

    assign rr_ptr_o = rr_ptr_q;
    assign bad_sel  = bad_sel_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_slot
        demux_out_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .load_i  (load_s[g]),
            .drain_i (drain_s[g]),
            .data_i  (in_data),
            .valid_o (out_valid[g]),
            .data_o  (out_data[g*WIDTH +: WIDTH])
`ifdef DEMUX_STREAM_CNT_EN
            ,
            .cnt_o   (cnt_out[g*CNT_W +: CNT_W])
`endif
        );
    end

endmodule
